// File: rtl/ah_snoopable_fifo_param.sv
// Parameterised synchronous FIFO with show-ahead read, occupancy-masked snoop and saturating hit counter.
// Optional macro AH_SFIFO_SNOOP_REG_EN registers smatch (1-cycle latency); default build drives it combinationally.
module ah_snoopable_fifo_param #(
    parameter int DATA_W  = 110,
    parameter int DEPTH   = 32,
    parameter int SNOOP_W = 32
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [DATA_W-1:0]          wdata,
    input  logic                       wvalid,
    output logic                       wready,
    output logic [DATA_W-1:0]          rdata,
    output logic                       rvalid,
    input  logic                       rready,
    input  logic [SNOOP_W-1:0]         sdata,
    input  logic                       svalid,
    output logic                       smatch,
    output logic [$clog2(DEPTH):0]     count,
    output logic [15:0]                hit_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [15:0]       hit_cnt_q, hit_cnt_d;
    logic              full_s, empty_s, wr_en_s, rd_en_s, hit_s;
    logic [PW-1:0]     count_s;
    logic [DEPTH-1:0]  occ_s, eq_s;

    assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_s = (wr_ptr_q == rd_ptr_q);
    assign count_s = wr_ptr_q - rd_ptr_q;
    assign wr_en_s = wvalid && !full_s;
    assign rd_en_s = rready && !empty_s;

    assign wready  = !full_s;
    assign rvalid  = !empty_s;
    assign count   = count_s;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];
    assign hit_cnt = hit_cnt_q;

    // An entry is live when its distance from the read pointer is below the occupancy,
    // so stale data left behind by pops can never produce a hit.
    for (genvar g = 0; g < DEPTH; g++) begin : g_snoop
        logic [AW-1:0] off_s;
        assign off_s    = AW'(g) - rd_ptr_q[AW-1:0];
        assign occ_s[g] = ({1'b0, off_s} < count_s);
        assign eq_s[g]  = (mem_q[g][SNOOP_W-1:0] == sdata);
    end

    assign hit_s = svalid && (|(occ_s & eq_s));

    // Next-state for storage, pointers and hit counter.
    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        hit_cnt_d = hit_cnt_q;
        if (wr_en_s) begin
            mem_d[wr_ptr_q[AW-1:0]] = wdata;
            wr_ptr_d                = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_en_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (hit_s && (hit_cnt_q != 16'hFFFF)) begin
            hit_cnt_d = hit_cnt_q + 16'd1;
        end else begin
            hit_cnt_d = hit_cnt_q;
        end
    end

    // State registers; reset also wipes storage so nothing survives a mid-burst reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            hit_cnt_q <= 16'd0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            hit_cnt_q <= hit_cnt_d;
            mem_q     <= mem_d;
        end
    end

`ifdef AH_SFIFO_SNOOP_REG_EN
    logic smatch_q;

    // Registered snoop result: reports the previous cycle's hit condition.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            smatch_q <= 1'b0;
        end else begin
            smatch_q <= hit_s;
        end
    end

    assign smatch = smatch_q;
`else
    assign smatch = hit_s;
`endif

endmodule

// File: tb/tb_ah_snoopable_fifo_param.sv
// Directed self-checking bench for ah_snoopable_fifo_param (default parameters, either smatch timing).
module tb_ah_snoopable_fifo_param;
    logic         clk;
    logic         rstn;
    logic [109:0] wdata;
    logic         wvalid;
    logic         wready;
    logic [109:0] rdata;
    logic         rvalid;
    logic         rready;
    logic [31:0]  sdata;
    logic         svalid;
    logic         smatch;
    logic [5:0]   count;
    logic [15:0]  hit_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [109:0] exp_d;
    logic [109:0] snp_word;

    ah_snoopable_fifo_param dut (
        .clk(clk), .rstn(rstn),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .sdata(sdata), .svalid(svalid), .smatch(smatch),
        .count(count), .hit_cnt(hit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic [109:0] d);
        wvalid = 1'b1;
        wdata  = d;
        @(posedge clk); #1;
        wvalid = 1'b0;
    endtask

    task automatic pop();
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b1; wvalid = 1'b0; rready = 1'b0; svalid = 1'b0;
        wdata = '0; sdata = 32'd0;
        #2 rstn = 1'b0;
        #1;
        vec_cnt++; if (count !== 6'd0) begin err_cnt++; $display("FAIL reset_count got %0d exp 0", count); end
        vec_cnt++; if (wready !== 1'b1) begin err_cnt++; $display("FAIL reset_wready got %b exp 1", wready); end
        vec_cnt++; if (rvalid !== 1'b0) begin err_cnt++; $display("FAIL reset_rvalid got %b exp 0", rvalid); end
        vec_cnt++; if (hit_cnt !== 16'd0) begin err_cnt++; $display("FAIL reset_hit_cnt got %0d exp 0", hit_cnt); end
        vec_cnt++; if (smatch !== 1'b0) begin err_cnt++; $display("FAIL reset_smatch got %b exp 0", smatch); end
        @(posedge clk); @(posedge clk); #3;
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fill_drain();
        wvalid = 1'b1; wdata = 110'd0;
        #1;
        vec_cnt++; if (rvalid !== 1'b0) begin err_cnt++; $display("FAIL no_fallthrough got %b exp 0", rvalid); end
        @(posedge clk); #1;
        wvalid = 1'b0;
        vec_cnt++; if (rvalid !== 1'b1) begin err_cnt++; $display("FAIL rvalid_next_cycle got %b exp 1", rvalid); end
        for (int i = 1; i < 32; i++) push(110'(i));
        vec_cnt++; if (count !== 6'd32) begin err_cnt++; $display("FAIL fill_count got %0d exp 32", count); end
        vec_cnt++; if (wready !== 1'b0) begin err_cnt++; $display("FAIL fill_wready got %b exp 0", wready); end
        for (int i = 0; i < 32; i++) begin
            exp_d = 110'(i);
            vec_cnt++; if (rdata !== exp_d) begin err_cnt++; $display("FAIL drain_data[%0d] got %0h exp %0h", i, rdata, exp_d); end
            pop();
        end
        vec_cnt++; if (rvalid !== 1'b0) begin err_cnt++; $display("FAIL drain_rvalid got %b exp 0", rvalid); end
        vec_cnt++; if (count !== 6'd0) begin err_cnt++; $display("FAIL drain_count got %0d exp 0", count); end
        pop();
        vec_cnt++; if (count !== 6'd0) begin err_cnt++; $display("FAIL empty_pop_count got %0d exp 0", count); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 20; i++) push(110'(i + 50));
        for (int i = 0; i < 20; i++) begin
            exp_d = 110'(i + 50);
            vec_cnt++; if (rdata !== exp_d) begin err_cnt++; $display("FAIL wrap_pre[%0d] got %0h exp %0h", i, rdata, exp_d); end
            pop();
        end
        for (int i = 0; i < 32; i++) push({78'(i * 3 + 1), 32'(i + 1000)});
        vec_cnt++; if (count !== 6'd32) begin err_cnt++; $display("FAIL wrap_count got %0d exp 32", count); end
        vec_cnt++; if (wready !== 1'b0) begin err_cnt++; $display("FAIL wrap_full got %b exp 0", wready); end
        for (int i = 0; i < 32; i++) begin
            exp_d = {78'(i * 3 + 1), 32'(i + 1000)};
            vec_cnt++; if (rdata !== exp_d) begin err_cnt++; $display("FAIL wrap_data[%0d] got %0h exp %0h", i, rdata, exp_d); end
            pop();
        end
        vec_cnt++; if (count !== 6'd0) begin err_cnt++; $display("FAIL wrap_end_count got %0d exp 0", count); end
    endtask

    task automatic test_full_concurrency();
        for (int i = 0; i < 32; i++) push(110'(i + 200));
        wvalid = 1'b1; wdata = 110'd999; rready = 1'b1;
        @(posedge clk); #1;
        wvalid = 1'b0; rready = 1'b0;
        vec_cnt++; if (count !== 6'd31) begin err_cnt++; $display("FAIL fullrw_count got %0d exp 31", count); end
        vec_cnt++; if (wready !== 1'b1) begin err_cnt++; $display("FAIL fullrw_wready got %b exp 1", wready); end
        for (int i = 0; i < 31; i++) begin
            exp_d = 110'(i + 201);
            vec_cnt++; if (rdata !== exp_d) begin err_cnt++; $display("FAIL fullrw_data[%0d] got %0h exp %0h", i, rdata, exp_d); end
            pop();
        end
        vec_cnt++; if (rvalid !== 1'b0) begin err_cnt++; $display("FAIL fullrw_rvalid got %b exp 0", rvalid); end
    endtask

    task automatic test_snoop();
        #2 rstn = 1'b0;
        #3 rstn = 1'b1;
        @(posedge clk); #1;
        snp_word = {78'h2BEEF, 32'hA5A5A5A5};
        for (int i = 1; i <= 5; i++) push(110'(i));
        push(snp_word);
        for (int i = 0; i < 6; i++) pop();
        vec_cnt++; if (count !== 6'd0) begin err_cnt++; $display("FAIL snoop_empty_count got %0d exp 0", count); end
        // stale entry 5 must not hit
        svalid = 1'b1; sdata = 32'hA5A5A5A5;
        #1;
`ifndef AH_SFIFO_SNOOP_REG_EN
        vec_cnt++; if (smatch !== 1'b0) begin err_cnt++; $display("FAIL snoop_stale got %b exp 0", smatch); end
`endif
        @(posedge clk); #1;
`ifdef AH_SFIFO_SNOOP_REG_EN
        vec_cnt++; if (smatch !== 1'b0) begin err_cnt++; $display("FAIL snoop_stale got %b exp 0", smatch); end
`endif
        svalid = 1'b0;
        vec_cnt++; if (hit_cnt !== 16'd0) begin err_cnt++; $display("FAIL snoop_stale_cnt got %0d exp 0", hit_cnt); end
        push(snp_word);
        svalid = 1'b1; sdata = 32'hA5A5A5A5;
        #1;
`ifndef AH_SFIFO_SNOOP_REG_EN
        vec_cnt++; if (smatch !== 1'b1) begin err_cnt++; $display("FAIL snoop_hit got %b exp 1", smatch); end
`endif
        @(posedge clk); #1;
`ifdef AH_SFIFO_SNOOP_REG_EN
        vec_cnt++; if (smatch !== 1'b1) begin err_cnt++; $display("FAIL snoop_hit got %b exp 1", smatch); end
`endif
        vec_cnt++; if (hit_cnt !== 16'd1) begin err_cnt++; $display("FAIL snoop_hit_cnt got %0d exp 1", hit_cnt); end
        sdata = 32'hA5A5A5A4;
        #1;
`ifndef AH_SFIFO_SNOOP_REG_EN
        vec_cnt++; if (smatch !== 1'b0) begin err_cnt++; $display("FAIL snoop_miss got %b exp 0", smatch); end
`endif
        @(posedge clk); #1;
`ifdef AH_SFIFO_SNOOP_REG_EN
        vec_cnt++; if (smatch !== 1'b0) begin err_cnt++; $display("FAIL snoop_miss got %b exp 0", smatch); end
`endif
        svalid = 1'b0;
        vec_cnt++; if (hit_cnt !== 16'd1) begin err_cnt++; $display("FAIL snoop_miss_cnt got %0d exp 1", hit_cnt); end
    endtask

    task automatic test_same_cycle();
        // write and snoop the same value together: new entry is invisible
        wvalid = 1'b1; wdata = {78'd0, 32'h12345678};
        svalid = 1'b1; sdata = 32'h12345678;
        #1;
`ifndef AH_SFIFO_SNOOP_REG_EN
        vec_cnt++; if (smatch !== 1'b0) begin err_cnt++; $display("FAIL same_cycle_write got %b exp 0", smatch); end
`endif
        @(posedge clk); #1;
`ifdef AH_SFIFO_SNOOP_REG_EN
        vec_cnt++; if (smatch !== 1'b0) begin err_cnt++; $display("FAIL same_cycle_write got %b exp 0", smatch); end
`endif
        wvalid = 1'b0;
        // pop the head while snooping it: still visible
        rready = 1'b1; sdata = 32'hA5A5A5A5;
        #1;
`ifndef AH_SFIFO_SNOOP_REG_EN
        vec_cnt++; if (smatch !== 1'b1) begin err_cnt++; $display("FAIL same_cycle_pop got %b exp 1", smatch); end
`endif
        @(posedge clk); #1;
`ifdef AH_SFIFO_SNOOP_REG_EN
        vec_cnt++; if (smatch !== 1'b1) begin err_cnt++; $display("FAIL same_cycle_pop got %b exp 1", smatch); end
`endif
        rready = 1'b0; svalid = 1'b0;
        vec_cnt++; if (hit_cnt !== 16'd2) begin err_cnt++; $display("FAIL same_cycle_cnt got %0d exp 2", hit_cnt); end
        vec_cnt++; if (count !== 6'd1) begin err_cnt++; $display("FAIL same_cycle_count got %0d exp 1", count); end
        exp_d = {78'd0, 32'h12345678};
        vec_cnt++; if (rdata !== exp_d) begin err_cnt++; $display("FAIL same_cycle_head got %0h exp %0h", rdata, exp_d); end
    endtask

    task automatic test_reset_midburst();
        pop();
        for (int i = 0; i < 7; i++) push(110'(i + 300));
        vec_cnt++; if (count !== 6'd7) begin err_cnt++; $display("FAIL midburst_count got %0d exp 7", count); end
        #2 rstn = 1'b0;
        #1;
        vec_cnt++; if (count !== 6'd0) begin err_cnt++; $display("FAIL async_count got %0d exp 0", count); end
        vec_cnt++; if (hit_cnt !== 16'd0) begin err_cnt++; $display("FAIL async_hit_cnt got %0d exp 0", hit_cnt); end
        vec_cnt++; if (rvalid !== 1'b0) begin err_cnt++; $display("FAIL async_rvalid got %b exp 0", rvalid); end
        vec_cnt++; if (wready !== 1'b1) begin err_cnt++; $display("FAIL async_wready got %b exp 1", wready); end
        #3 rstn = 1'b1;
        @(posedge clk); #1;
        vec_cnt++; if (rvalid !== 1'b0) begin err_cnt++; $display("FAIL post_reset_rvalid got %b exp 0", rvalid); end
        push(110'd77);
        exp_d = 110'd77;
        vec_cnt++; if (rdata !== exp_d) begin err_cnt++; $display("FAIL post_reset_data got %0h exp %0h", rdata, exp_d); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_wrap();
        test_full_concurrency();
        test_snoop();
        test_same_cycle();
        test_reset_midburst();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
